// File: rtl/bus_xfer_ctrl.sv
// rtl/bus_xfer_ctrl.sv - strobe sequencer for a bank of latch/enable registers
//
// Accepts one MOVE/LOAD/READ request at a time (req_valid/req_ready) and
// walks the register bank through the en -> capture -> latch sequence.
// Ports:
//   clk, rst                clock, synchronous active-high reset
//   req_valid/req_ready     request handshake
//   req_op/src/dst/imm      request fields (00 MOVE, 01 LOAD, 10 READ)
//   reg_data                flattened data_out of all registers
//   latch, en               per-register strobes (one-hot or zero)
//   bus_out                 byte driven to every register's data_in
//   done, err               completion pulse and reject flag
//   rd_valid, rd_data       READ result pulse and held value
module bus_xfer_ctrl #(
    parameter int N_REGS = 4,
    parameter int SEL_W  = 2,
    parameter int DATA_W = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [1:0]               req_op,
    input  logic [SEL_W-1:0]         req_src,
    input  logic [SEL_W-1:0]         req_dst,
    input  logic [DATA_W-1:0]        req_imm,
    input  logic [N_REGS*DATA_W-1:0] reg_data,
    output logic [N_REGS-1:0]        latch,
    output logic [N_REGS-1:0]        en,
    output logic [DATA_W-1:0]        bus_out,
    output logic                     done,
    output logic                     err,
    output logic                     rd_valid,
    output logic [DATA_W-1:0]        rd_data
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_EN,
        S_CAP,
        S_LAT,
        S_RESP
    } state_t;

    localparam logic [1:0] OP_MOVE = 2'b00;
    localparam logic [1:0] OP_LOAD = 2'b01;
    localparam logic [1:0] OP_READ = 2'b10;

    state_t              state;
    state_t              state_nx;
    logic [1:0]          op_q;
    logic [SEL_W-1:0]    src_q;
    logic [SEL_W-1:0]    dst_q;
    logic [DATA_W-1:0]   imm_q;
    logic                err_q;
    logic [DATA_W-1:0]   hold;
    logic [DATA_W-1:0]   rd_q;

    logic                accept;
    logic                src_bad;
    logic                dst_bad;
    logic                req_bad;
    logic [DATA_W-1:0]   src_word;

    assign req_ready = (state == S_IDLE) && !rst;
    assign accept    = req_valid && req_ready;

    // An index is only out of range if the op actually uses it.
    assign src_bad = 32'(req_src) >= N_REGS;
    assign dst_bad = 32'(req_dst) >= N_REGS;
    assign req_bad = (req_op == 2'b11)
                  || (((req_op == OP_MOVE) || (req_op == OP_READ)) && src_bad)
                  || (((req_op == OP_MOVE) || (req_op == OP_LOAD)) && dst_bad);

    // Select the source register's data_out; only meaningful in CAP.
    always_comb begin
        src_word = '0;
        for (int i = 0; i < N_REGS; i++) begin
            if (src_q == SEL_W'(i)) begin
                src_word = reg_data[i*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    if (req_bad) begin
                        state_nx = S_RESP;
                    end else if (req_op == OP_LOAD) begin
                        state_nx = S_LAT;
                    end else begin
                        state_nx = S_EN;
                    end
                end
            end
            S_EN:    state_nx = S_CAP;
            S_CAP:   state_nx = (op_q == OP_MOVE) ? S_LAT : S_RESP;
            S_LAT:   state_nx = S_IDLE;
            S_RESP:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            op_q  <= '0;
            src_q <= '0;
            dst_q <= '0;
            imm_q <= '0;
            err_q <= 1'b0;
            hold  <= '0;
            rd_q  <= '0;
        end else begin
            state <= state_nx;
            if (accept) begin
                op_q  <= req_op;
                src_q <= req_src;
                dst_q <= req_dst;
                imm_q <= req_imm;
                err_q <= req_bad;
            end
            // The register refreshed data_out at the end of EN, so CAP sees it.
            if (state == S_CAP) begin
                hold <= src_word;
                if (op_q == OP_READ) begin
                    rd_q <= src_word;
                end
            end
        end
    end

    always_comb begin
        en      = '0;
        latch   = '0;
        bus_out = '0;
        for (int i = 0; i < N_REGS; i++) begin
            en[i]    = (state == S_EN)  && (src_q == SEL_W'(i));
            latch[i] = (state == S_LAT) && (dst_q == SEL_W'(i));
        end
        if (state == S_LAT) begin
            bus_out = (op_q == OP_LOAD) ? imm_q : hold;
        end
    end

    assign done     = (state == S_LAT) || (state == S_RESP);
    assign err      = (state == S_RESP) && err_q;
    assign rd_valid = (state == S_RESP) && !err_q;
    assign rd_data  = rd_q;

endmodule

// File: tb/tb_bus_xfer_ctrl.sv
// tb/tb_bus_xfer_ctrl.sv - randomized self-checking bench for bus_xfer_ctrl
module tb_bus_xfer_ctrl;

    localparam int NR = 3;

    logic            clk = 1'b0;
    logic            rst;
    logic            req_valid;
    logic            req_ready;
    logic [1:0]      req_op;
    logic [1:0]      req_src;
    logic [1:0]      req_dst;
    logic [7:0]      req_imm;
    logic [NR*8-1:0] reg_data;
    logic [NR-1:0]   latch;
    logic [NR-1:0]   en;
    logic [7:0]      bus_out;
    logic            done;
    logic            err;
    logic            rd_valid;
    logic [7:0]      rd_data;

    int n_cmp = 0;
    int n_bad = 0;
    logic mon_on = 1'b0;

    // Register bank attached to the controller (latch stores, en refreshes data_out).
    logic [7:0] bank_store [NR] = '{default: 8'h00};
    logic [7:0] bank_dout  [NR] = '{default: 8'h00};

    // Reference: architectural register contents and last READ result.
    logic [7:0] mdl [NR] = '{default: 8'h00};
    logic [7:0] mdl_rd = 8'h00;

    always #5 clk = ~clk;

    bus_xfer_ctrl #(.N_REGS(NR), .SEL_W(2), .DATA_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_src   (req_src),
        .req_dst   (req_dst),
        .req_imm   (req_imm),
        .reg_data  (reg_data),
        .latch     (latch),
        .en        (en),
        .bus_out   (bus_out),
        .done      (done),
        .err       (err),
        .rd_valid  (rd_valid),
        .rd_data   (rd_data)
    );

    always @(posedge clk) begin
        for (int i = 0; i < NR; i++) begin
            if (latch[i]) bank_store[i] <= bus_out;
            if (en[i])    bank_dout[i]  <= bank_store[i];
        end
    end
    assign reg_data = {bank_dout[2], bank_dout[1], bank_dout[0]};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (mon_on) begin
            check("en_onehot",  32'($onehot0(en)), 1);
            check("lat_onehot", 32'($onehot0(latch)), 1);
            check("no_overlap", 32'((en != 0) && (latch != 0)), 0);
            check("bus_idle",   (latch == 0) ? 32'(bus_out) : 0, 0);
            check("err_gate",   32'(err && !done), 0);
        end
    end

    // Issue one request from an idle cycle and check it cycle by cycle.
    task automatic xfer(input logic [1:0] op, input logic [1:0] src,
                        input logic [1:0] dst, input logic [7:0] imm);
        logic       bad;
        int         lat;
        logic [7:0] val;
        logic [2:0] exp_en;
        logic [2:0] exp_lat;
        bad = (op == 2'b11) || ((op != 2'b01) && (src >= 2'(NR)))
                            || ((op != 2'b10) && (dst >= 2'(NR)));
        lat = (bad || op == 2'b01) ? 1 : 3;
        if (op == 2'b01)        val = imm;
        else if (src < 2'(NR))  val = mdl[src];
        else                    val = 8'h00;
        req_op = op; req_src = src; req_dst = dst; req_imm = imm; req_valid = 1'b1;
        @(negedge clk);
        check("ready", 32'(req_ready), 1);
        @(posedge clk); #1;
        for (int k = 1; k <= lat; k++) begin
            req_valid = (k < lat) ? 1'($urandom) : 1'b0;
            req_op    = 2'($urandom);
            req_src   = 2'($urandom);
            req_dst   = 2'($urandom);
            req_imm   = 8'($urandom);
            @(negedge clk);
            exp_en  = (!bad && op != 2'b01 && k == 1)   ? (3'b001 << src) : 3'b000;
            exp_lat = (!bad && op != 2'b10 && k == lat) ? (3'b001 << dst) : 3'b000;
            check("en",        32'(en), 32'(exp_en));
            check("latch",     32'(latch), 32'(exp_lat));
            check("done",      32'(done), 32'(k == lat));
            check("busy_rdy",  32'(req_ready), 0);
            if (k == lat) begin
                check("err",      32'(err), 32'(bad));
                check("rd_valid", 32'(rd_valid), 32'(!bad && op == 2'b10));
                if (!bad && op == 2'b10) mdl_rd = val;
                check("rd_data",  32'(rd_data), 32'(mdl_rd));
                if (exp_lat != 0) check("bus_out", 32'(bus_out), 32'(val));
            end
            @(posedge clk); #1;
        end
        if (!bad && op != 2'b10) mdl[dst] = val;
        for (int i = 0; i < NR; i++) check("reg_content", 32'(bank_store[i]), 32'(mdl[i]));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_op = '0; req_src = '0; req_dst = '0; req_imm = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_ready",   32'(req_ready), 0);
        check("rst_done",    32'(done), 0);
        check("rst_strobes", 32'({en, latch}), 0);
        check("rst_bus",     32'(bus_out), 0);
        check("rst_rd",      32'({rd_valid, err, rd_data}), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        mon_on = 1'b1;
        @(negedge clk);
        check("ready_after_rst", 32'(req_ready), 1);
        @(posedge clk); #1;

        xfer(2'b01, 2'd0, 2'd2, 8'hA5);
        xfer(2'b01, 2'd0, 2'd1, 8'h3C);
        xfer(2'b00, 2'd1, 2'd0, 8'h00);
        xfer(2'b01, 2'd0, 2'd0, 8'h7F);
        xfer(2'b10, 2'd0, 2'd0, 8'h00);
        xfer(2'b01, 2'd0, 2'd1, 8'h11);
        xfer(2'b00, 2'd1, 2'd3, 8'h00);
        xfer(2'b11, 2'd0, 2'd0, 8'h00);
        xfer(2'b01, 2'd0, 2'd2, 8'h5A);
        xfer(2'b00, 2'd2, 2'd2, 8'h00);
        xfer(2'b10, 2'd3, 2'd0, 8'h00);

        // Reset during CAP of a MOVE: the transfer is dropped.
        req_op = 2'b00; req_src = 2'd2; req_dst = 2'd0; req_imm = '0; req_valid = 1'b1;
        @(negedge clk);
        check("mid_ready", 32'(req_ready), 1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        check("mid_done",    32'(done), 0);
        check("mid_strobes", 32'({en, latch}), 0);
        check("mid_bus",     32'(bus_out), 0);
        check("mid_ready0",  32'(req_ready), 0);
        check("mid_rd",      32'({rd_valid, err, rd_data}), 0);
        mdl_rd = 8'h00;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("mid_ready1",  32'(req_ready), 1);
        check("mid_dst",     32'(bank_store[0]), 32'(mdl[0]));
        @(posedge clk); #1;

        for (int n = 0; n < 200; n++) begin
            int gap;
            xfer(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                 2'($urandom_range(0, 3)), 8'($urandom));
            gap = $urandom_range(0, 2);
            repeat (gap) begin
                @(posedge clk); #1;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/bus_xfer_ctrl.md
# bus_xfer_ctrl

- Sequencing controller that drives the `latch`/`en` strobes of a bank of 8-bit latch/enable registers on the processor's internal data bus.
- Accepts one transfer request at a time over a valid/ready handshake:
  - MOVE: register to register
  - LOAD: immediate to register
  - READ: register to controller
- Generates the required strobe sequence and returns completion, read data and an error flag.
- It is the initiator side of the register strobe interface. It sits between the control unit and the register bank.

## Interface

Parameters:
- `N_REGS`, default 4: number of attached registers (2..8).
- `SEL_W`, default 2: width of register select fields; `N_REGS` ≤ 2**`SEL_W`.
- `DATA_W`, default 8: bus and register width.

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  controller idle and able to accept.
- `req_op`  in  2  00 MOVE, 01 LOAD, 10 READ, 11 reserved.
- `req_src`  in  SEL_W  source register index (MOVE, READ).
- `req_dst`  in  SEL_W  destination register index (MOVE, LOAD).
- `req_imm`  in  DATA_W  immediate byte (LOAD).
- `reg_data`  in  N_REGS*DATA_W  flattened `data_out` of all registers; register i occupies bits [i*DATA_W +: DATA_W].
- `latch`  out  N_REGS  per-register latch strobe (one-hot or zero).
- `en`  out  N_REGS  per-register output-enable strobe (one-hot or zero).
- `bus_out`  out  DATA_W  byte driven to all registers' `data_in`.
- `done`  out  1  one-cycle completion pulse.
- `err`  out  1  valid with `done`: request rejected.
- `rd_valid`  out  1  one-cycle pulse, READ data valid.
- `rd_data`  out  DATA_W  READ result; holds its value until the next READ.

## Operation

- States: IDLE, EN, CAP, LAT, RESP.
- `req_ready` = (state == IDLE) && !`rst`. A request is accepted on a cycle with `req_valid && req_ready`. At acceptance, `req_op`, `req_src`, `req_dst` and `req_imm` are registered.
- Validation at accept: `err` is set if op = 11, or if any used index is ≥ `N_REGS`. For MOVE both indices are checked; for LOAD only `dst`; for READ only `src`.
  - An erroring request goes IDLE→RESP.
  - No `latch` or `en` strobe is issued.
- MOVE: IDLE→EN→CAP→LAT→IDLE.
  - EN: `en[src]`=1.
  - CAP: the hold register is loaded from `reg_data[src]` (the register updated `data_out` at the end of EN).
  - LAT: `bus_out`=hold, `latch[dst]`=1, `done`=1.
- LOAD: IDLE→LAT→IDLE.
  - LAT: `bus_out`=captured imm, `latch[dst]`=1, `done`=1.
- READ: IDLE→EN→CAP→RESP→IDLE.
  - RESP: `rd_data`=hold, `rd_valid`=1, `done`=1.
- RESP for an erroring request: `done`=1, `err`=1, `rd_valid`=0, `rd_data` unchanged.
- `err` is 0 whenever `done` is 0.
- `en` and `latch` are never asserted in the same cycle, and at most one bit of each is set.
- `bus_out` is 0 in every state except LAT.
- MOVE with `src` == `dst` is legal and writes back the same value.
- The controller does not track register contents. A register that is reset independently returns whatever its `data_out` shows.

## Timing

- Reset values: all outputs 0, state IDLE, hold register 0, `rd_data` 0.
- `req_ready` is 0 while `rst`=1 and is 1 on the first cycle after `rst` deasserts.
- Reset asserted mid-transfer: on the next edge all strobes are 0, state is IDLE and the transfer is dropped. No `done` is issued. A partially completed MOVE may leave the destination unwritten.
- Latency from accept cycle T:
  - MOVE: `done` in T+3.
  - READ: `done` and `rd_valid` in T+3.
  - LOAD: `done` in T+1.
  - Error: `done` and `err` in T+1.
- `req_ready` returns to 1 in the cycle after the `done` cycle. Back-to-back requests are therefore spaced 4 cycles (MOVE/READ) or 2 cycles (LOAD/error).
- Request inputs are ignored when `req_ready`=0. Held inputs need not stay stable after acceptance.
- `reg_data` is sampled only in CAP.

## Test plan

- Reset then LOAD dst=2 imm=0xA5: `done` at T+1. `latch`=0100 for exactly that cycle, `bus_out`=0xA5. Register 2 model reads 0xA5.
- Preload reg1=0x3C, then MOVE src=1 dst=3:
  - `en`=0010 at T+1.
  - `latch`=1000 with `bus_out`=0x3C and `done`=1 at T+3.
  - Register 3 ends at 0x3C; `err`=0.
- READ src=0 with reg0=0x7F: `rd_valid`=`done`=1 and `rd_data`=0x7F at T+3. `rd_data` holds 0x7F through a following LOAD.
- N_REGS=3: MOVE dst=3 gives `done`=`err`=1 at T+1 with no strobes. Op=11 gives the same result. The next request is accepted at T+2.
- Assert `rst` during the CAP cycle of a MOVE: next cycle all outputs are 0, no `done`, and `req_ready`=1 one cycle after `rst` drops.
- Random stream of 200 valid/invalid requests against a register-bank model: one-hot strobes, `en`/`latch` never coincident, and all latencies and contents match the model.
